// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error sweep of an external approximate |a-b| circuit, with exact reference and error metrics.
// Latency: 2^IW*SETTLE cycles from an accepted start to the one-cycle done pulse; all outputs registered.
// Backpressure: none; start is ignored outside IDLE, abort cancels a running sweep at the next edge.
module abs_diff_err_sweep #(
   parameter int IW     = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [IW-1:0]        vec_o,
   input  logic [IW/2-1:0]      apx_i,
   output logic                 busy,
   output logic                 done,
   output logic [IW:0]          err_cnt,
   output logic [IW/2-1:0]      max_err,
   output logic [IW+IW/2-1:0]   sum_err
);

   localparam int EW = IW / 2;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [IW-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        vec_nxt;
   logic [IW:0]          err_cnt_nxt;
   logic [EW-1:0]        max_err_nxt;
   logic [IW+EW-1:0]     sum_err_nxt;

   logic [EW-1:0]        op_a, op_b, exact, err_mag;
   logic                 sample;

   // Exact reference and error magnitude for the vector currently presented.
   always_comb begin
      op_a    = vec_o[IW-1:EW];
      op_b    = vec_o[EW-1:0];
      exact   = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
      err_mag = (exact >= apx_i) ? (exact - apx_i) : (apx_i - exact);
      sample  = (cnt == CNT_LAST);
   end

   // Next state plus next values of the sweep vector, settle counter and metrics.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      vec_nxt     = vec_o;
      err_cnt_nxt = err_cnt;
      max_err_nxt = max_err;
      sum_err_nxt = sum_err;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_RUN;
               cnt_nxt     = '0;
               vec_nxt     = '0;
               err_cnt_nxt = '0;
               max_err_nxt = '0;
               sum_err_nxt = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               // Cancel without accumulating the vector sampled at this edge.
               state_nxt = S_IDLE;
            end else if (sample) begin
               err_cnt_nxt = err_cnt + {{IW{1'b0}}, (err_mag != '0)};
               max_err_nxt = (err_mag > max_err) ? err_mag : max_err;
               sum_err_nxt = sum_err + {{IW{1'b0}}, err_mag};
               cnt_nxt     = '0;
               if (vec_o == VEC_LAST) begin
                  // Last vector: hold it rather than wrapping to zero.
                  state_nxt = S_DONE;
               end else begin
                  vec_nxt = vec_o + IW'(1);
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and status registers; busy/done are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         vec_o   <= '0;
         err_cnt <= '0;
         max_err <= '0;
         sum_err <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         vec_o   <= vec_nxt;
         err_cnt <= err_cnt_nxt;
         max_err <= max_err_nxt;
         sum_err <= sum_err_nxt;
         busy    <= (state_nxt == S_RUN);
         done    <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Bench for abs_diff_err_sweep: two instances (SETTLE=1 and SETTLE=3) swept against a reference model.
// Latency: checks done at 16 and 48 cycles after start respectively.
// Backpressure: none; exercises abort, ignored starts and mid-sweep reset.
module tb_abs_diff_err_sweep;

   localparam int IW = 4;
   localparam int EW = IW / 2;
   localparam int NV = 1 << IW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort1 = 1'b0;
   logic            abort3 = 1'b0;
   logic [IW-1:0]   vec1, vec3;
   logic [EW-1:0]   apx1, apx3;
   logic            busy1, done1, busy3, done3;
   logic [IW:0]     ec1, ec3;
   logic [EW-1:0]   me1, me3;
   logic [IW+EW-1:0] se1, se3;

   int checks = 0;
   int errors = 0;
   int mode = 0;          // 0 exact, 1 tied 0, 2 exact^1, 3 random table
   int lut [NV];

   always #5 clk = ~clk;

   function automatic int exact_of(input int v);
      int a, b;
      a = v / (1 << EW);
      b = v % (1 << EW);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic logic [EW-1:0] apx_sel(input int m, input int v, input int l);
      int x;
      x = exact_of(v);
      case (m)
         0:       return EW'(x);
         1:       return '0;
         2:       return EW'(x ^ 1);
         default: return EW'(l);
      endcase
   endfunction

   assign apx1 = apx_sel(mode, int'(vec1), lut[vec1]);
   assign apx3 = apx_sel(mode, int'(vec3), lut[vec3]);

   abs_diff_err_sweep #(.IW(IW), .SETTLE(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort1),
      .vec_o(vec1), .apx_i(apx1), .busy(busy1), .done(done1),
      .err_cnt(ec1), .max_err(me1), .sum_err(se1)
   );

   abs_diff_err_sweep #(.IW(IW), .SETTLE(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort3),
      .vec_o(vec3), .apx_i(apx3), .busy(busy3), .done(done3),
      .err_cnt(ec3), .max_err(me3), .sum_err(se3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Metrics over vectors 0..n-1 from plain arithmetic.
   task automatic model(input int n, output int cnt, output int mx, output int sum);
      int e;
      cnt = 0; mx = 0; sum = 0;
      for (int v = 0; v < n; v++) begin
         e = exact_of(v) - int'(apx_sel(mode, v, lut[v]));
         if (e < 0) e = -e;
         if (e != 0) cnt++;
         if (e > mx) mx = e;
         sum += e;
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " vec1"}, vec1, 0);   chk({tag, " busy1"}, busy1, 0);
      chk({tag, " done1"}, done1, 0); chk({tag, " ec1"}, ec1, 0);
      chk({tag, " me1"}, me1, 0);     chk({tag, " se1"}, se1, 0);
      chk({tag, " vec3"}, vec3, 0);   chk({tag, " busy3"}, busy3, 0);
      chk({tag, " done3"}, done3, 0); chk({tag, " ec3"}, ec3, 0);
      chk({tag, " me3"}, me3, 0);     chk({tag, " se3"}, se3, 0);
   endtask

   // One sweep on both instances; abort_at >= 0 aborts u_d1 while it presents that vector.
   task automatic run_sweep(input int abort_at);
      int  fc, fm, fs, pc, pm, ps;
      bit  aborted;
      bit  extra_starts;
      aborted = 0;
      extra_starts = (abort_at < 0);
      model(NV, fc, fm, fs);
      pc = 0; pm = 0; ps = 0;
      if (abort_at >= 0) model(abort_at, pc, pm, ps);

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start busy1", busy1, 1);
      chk("start busy3", busy3, 1);
      chk("start vec1", vec1, 0);
      chk("start clr ec1", ec1, 0);
      chk("start clr me1", me1, 0);
      chk("start clr se1", se1, 0);
      chk("start clr ec3", ec3, 0);

      for (int c = 1; c <= 50; c++) begin
         if (abort_at >= 0 && !aborted && busy1 && int'(vec1) == abort_at) abort1 = 1'b1;
         // Starts sampled while in RUN (edge 8) and in DONE (edge 17) must be ignored.
         if (extra_starts && (c == 8 || c == 17)) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (abort1) begin
            abort1 = 1'b0;
            aborted = 1;
            chk("abort busy1", busy1, 0);
            chk("abort ec1", ec1, pc);
            chk("abort me1", me1, pm);
            chk("abort se1", se1, ps);
         end
         chk("done1", done1, (c == NV && !aborted));
         chk("done3", done3, (c == 3 * NV));
         if (!aborted && c <= NV) begin
            chk("vec1", vec1, (c < NV) ? c : NV - 1);
            chk("busy1", busy1, (c < NV));
         end
         if (!aborted && c > NV) chk("busy1 idle", busy1, 0);
         if (c <= 3 * NV) begin
            chk("vec3 hold", vec3, (c < 3 * NV) ? c / 3 : NV - 1);
            chk("busy3", busy3, (c < 3 * NV));
         end
         if (c == NV && !aborted) begin
            chk("final ec1", ec1, fc);
            chk("final me1", me1, fm);
            chk("final se1", se1, fs);
         end
         if (c == 3 * NV) begin
            chk("final ec3", ec3, fc);
            chk("final me3", me3, fm);
            chk("final se3", se3, fs);
         end
      end
      chk("end busy1", busy1, 0);
      chk("end busy3", busy3, 0);
      if (!aborted) begin
         chk("hold ec1", ec1, fc);
         chk("hold se1", se1, fs);
      end else begin
         chk("hold abort ec1", ec1, pc);
      end
   endtask

   initial begin
      for (int i = 0; i < NV; i++) lut[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst_n = 1'b1;

      mode = 0;
      run_sweep(-1);
      chk("exact ec", ec1, 0);
      chk("exact me", me1, 0);
      chk("exact se", se1, 0);

      mode = 1;
      run_sweep(-1);
      chk("tie0 ec", ec1, 12);
      chk("tie0 me", me1, 3);
      chk("tie0 se", se1, 20);
      chk("tie0 ec3", ec3, 12);
      chk("tie0 se3", se3, 20);

      mode = 2;
      run_sweep(-1);
      chk("xor1 ec", ec1, 16);
      chk("xor1 me", me1, 1);
      chk("xor1 se", se1, 16);

      // Abort in the cycle vec_o=4 is presented: vectors 0..3 accumulated.
      mode = 1;
      run_sweep(4);
      chk("abort4 ec", ec1, 3);
      chk("abort4 se", se1, 6);

      // Abort on the final vector takes priority over the last sample.
      run_sweep(NV - 1);

      for (int r = 0; r < 5; r++) begin
         int ab;
         mode = 3;
         for (int i = 0; i < NV; i++) lut[i] = int'($urandom_range(0, 3));
         ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NV - 1));
         run_sweep(ab);
      end

      // Reset in the middle of a sweep clears everything immediately.
      mode = 1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(negedge clk) rst_n = 1'b1;
      run_sweep(-1);
      chk("post reset ec", ec1, 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
